// File: rtl/dma_io_responder_if.sv
// Bus bundle for the DMA I/O responder: controller handshake, system data bus,
// local tx/rx FIFO ports, and the sticky status flags.
interface dma_io_responder_if #(
    parameter int DW = 8
);
    logic          DREQ;
    logic          DACK;
    logic          IOR_N;
    logic          IOW_N;
    logic          EOP_N;
    logic [DW-1:0] DB_IN;
    logic [DW-1:0] DB_OUT;
    logic          DB_OE;
    logic          EN;
    logic          DIR;
    logic          DEMAND;
    logic          TX_VALID;
    logic [DW-1:0] TX_DATA;
    logic          TX_READY;
    logic          RX_VALID;
    logic [DW-1:0] RX_DATA;
    logic          RX_READY;
    logic          TC_DONE;
    logic          UNDERRUN;
    logic          CLR;

    modport slave (
        input  DACK, IOR_N, IOW_N, EOP_N, DB_IN, EN, DIR, DEMAND,
               TX_VALID, TX_DATA, RX_READY, CLR,
        output DREQ, DB_OUT, DB_OE, TX_READY, RX_VALID, RX_DATA, TC_DONE, UNDERRUN
    );

    modport master (
        output DACK, IOR_N, IOW_N, EOP_N, DB_IN, EN, DIR, DEMAND,
               TX_VALID, TX_DATA, RX_READY, CLR,
        input  DREQ, DB_OUT, DB_OE, TX_READY, RX_VALID, RX_DATA, TC_DONE, UNDERRUN
    );
endinterface

// File: rtl/dma_io_responder.sv
// DMA I/O responder: raises DREQ, services IOR/IOW strobes from a tx FIFO into
// an rx FIFO, and handles single/demand modes, EOP termination and aborts.
module dma_io_responder #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input logic              CLK,
    input logic              RESET_N,
    dma_io_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {IDLE, REQ, XFER, GAP, TERM} stateT;

    stateT         state, stateNext;
    logic          dreq;

    logic [DW-1:0] txMem [DEPTH];
    logic [DW-1:0] rxMem [DEPTH];
    logic [AW-1:0] txWrPtr, txRdPtr, rxWrPtr, rxRdPtr;
    logic [CW-1:0] txCount, rxCount, txCountNext, rxCountNext;
    logic          txFull, txEmpty, rxFull, rxEmpty;
    logic          txPush, txPop, rxPush, rxPop;

    logic          activeStrobeN, inXfer, strobeLow, strobeDone;
    logic          strobePrevLow, eopSeen, eopHit, rdUnder;
    logic          reqCond, reqCondNext;
    logic          txReady, dbOe, tcDone, underrun;
    logic [DW-1:0] dbOut;

    assign txFull  = (txCount == CW'(DEPTH));
    assign txEmpty = (txCount == '0);
    assign rxFull  = (rxCount == CW'(DEPTH));
    assign rxEmpty = (rxCount == '0);

    // Only the strobe matching DIR is watched; the other one is ignored.
    assign activeStrobeN = bus.DIR ? bus.IOW_N : bus.IOR_N;
    assign inXfer        = (state == XFER) && bus.DACK;
    assign strobeLow     = inXfer && !activeStrobeN;
    assign strobeDone    = inXfer && strobePrevLow && activeStrobeN;
    assign eopHit        = eopSeen || !bus.EOP_N;

    assign txPush = bus.TX_VALID && !txFull;
    assign txPop  = strobeDone && !bus.DIR && !rdUnder;
    assign rxPush = strobeDone && bus.DIR && !rxFull;
    assign rxPop  = !rxEmpty && bus.RX_READY;

    assign txCountNext = txCount + CW'(txPush) - CW'(txPop);
    assign rxCountNext = rxCount + CW'(rxPush) - CW'(rxPop);

    assign reqCond     = bus.EN && (bus.DIR ? !rxFull : !txEmpty);
    // Demand-mode continuation looks at FIFO levels after this cycle's transfer.
    assign reqCondNext = bus.EN && (bus.DIR ? (rxCountNext != CW'(DEPTH))
                                            : (txCountNext != '0));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= stateNext;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        stateNext = state;
        dreq      = 1'b0;
        case (state)
            IDLE: if (reqCond) stateNext = REQ;
            REQ: begin
                dreq = 1'b1;
                if (!bus.EN)       stateNext = IDLE;
                else if (bus.DACK) stateNext = XFER;
            end
            XFER: begin
                dreq = 1'b1;
                if (!bus.DACK) begin
                    stateNext = IDLE;
                end else if (strobeDone) begin
                    if (eopHit)                        stateNext = TERM;
                    else if (bus.DEMAND && reqCondNext) stateNext = XFER;
                    else                               stateNext = GAP;
                end else if (!bus.EN && !strobePrevLow && activeStrobeN) begin
                    stateNext = GAP;
                end
            end
            GAP:     if (!bus.DACK) stateNext = IDLE;
            TERM:    if (!bus.DACK && !bus.EN) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            strobePrevLow <= 1'b0;
            eopSeen       <= 1'b0;
            rdUnder       <= 1'b0;
            dbOe          <= 1'b0;
            dbOut         <= '0;
            underrun      <= 1'b0;
            tcDone        <= 1'b0;
            txReady       <= 1'b1;
        end else begin
            strobePrevLow <= strobeLow;
            eopSeen       <= inXfer && !strobeDone && eopHit;
            dbOe          <= strobeLow && !bus.DIR;
            txReady       <= (txCountNext != CW'(DEPTH));

            // Data and underrun status are frozen at the first low sample of IOR.
            if (strobeLow && !bus.DIR) begin
                if (!strobePrevLow) begin
                    dbOut   <= txEmpty ? {DW{1'b1}} : txMem[txRdPtr];
                    rdUnder <= txEmpty;
                end
            end else begin
                dbOut <= '0;
            end

            if (strobeLow && !bus.DIR && !strobePrevLow && txEmpty) underrun <= 1'b1;
            else if (bus.CLR)                                       underrun <= 1'b0;

            if (state == XFER && stateNext == TERM) tcDone <= 1'b1;
            else if (bus.CLR)                       tcDone <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            txWrPtr <= '0;
            txRdPtr <= '0;
            txCount <= '0;
            rxWrPtr <= '0;
            rxRdPtr <= '0;
            rxCount <= '0;
        end else begin
            if (txPush) txWrPtr <= txWrPtr + AW'(1);
            if (txPop)  txRdPtr <= txRdPtr + AW'(1);
            if (rxPush) rxWrPtr <= rxWrPtr + AW'(1);
            if (rxPop)  rxRdPtr <= rxRdPtr + AW'(1);
            txCount <= txCountNext;
            rxCount <= rxCountNext;
        end
    end

    // NOTE: storage arrays are not reset; emptiness is defined by the reset pointers and counts.
    always_ff @(posedge CLK) begin
        if (txPush) txMem[txWrPtr] <= bus.TX_DATA;
        if (rxPush) rxMem[rxWrPtr] <= bus.DB_IN;
    end

    assign bus.DREQ     = dreq;
    assign bus.DB_OUT   = dbOut;
    assign bus.DB_OE    = dbOe;
    assign bus.TX_READY = txReady;
    assign bus.RX_VALID = !rxEmpty;
    assign bus.RX_DATA  = rxMem[rxRdPtr];
    assign bus.TC_DONE  = tcDone;
    assign bus.UNDERRUN = underrun;
endmodule

// File: tb/tb_dma_io_responder.sv
// Directed bench for dma_io_responder: single/demand transfers, EOP termination,
// underrun, DACK abort and reset with a full FIFO.
module tb_dma_io_responder;
    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rstN;
    int   assertCount = 0;
    int   failCount   = 0;

    dma_io_responder_if #(.DW(DW)) bus();

    dma_io_responder #(.DEPTH(DEPTH), .DW(DW)) dut (
        .CLK    (clk),
        .RESET_N(rstN),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached (got running, expected finished)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushTx(input logic [DW-1:0] d);
        bus.TX_VALID = 1'b1;
        bus.TX_DATA  = d;
        tick();
        bus.TX_VALID = 1'b0;
    endtask

    task automatic iorCycle(input string tag, input logic [DW-1:0] expData, input logic withEop);
        bus.IOR_N = 1'b0;
        bus.EOP_N = !withEop;
        tick();
        check({tag, "_oe"}, 32'(bus.DB_OE), 32'd1);
        check({tag, "_db"}, 32'(bus.DB_OUT), 32'(expData));
        bus.IOR_N = 1'b1;
        bus.EOP_N = 1'b1;
        tick();
    endtask

    logic [DW-1:0] wdata [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        bus.DACK = 0; bus.IOR_N = 1; bus.IOW_N = 1; bus.EOP_N = 1;
        bus.DB_IN = '0; bus.EN = 0; bus.DIR = 0; bus.DEMAND = 0;
        bus.TX_VALID = 0; bus.TX_DATA = '0; bus.RX_READY = 0; bus.CLR = 0;
        rstN = 1'b1;
        #1 rstN = 1'b0;
        #2;
        check("rst_dreq",     32'(bus.DREQ),     32'd0);
        check("rst_oe",       32'(bus.DB_OE),    32'd0);
        check("rst_db",       32'(bus.DB_OUT),   32'd0);
        check("rst_txready",  32'(bus.TX_READY), 32'd1);
        check("rst_rxvalid",  32'(bus.RX_VALID), 32'd0);
        check("rst_tcdone",   32'(bus.TC_DONE),  32'd0);
        check("rst_underrun", 32'(bus.UNDERRUN), 32'd0);
        tick();
        tick();
        rstN = 1'b1;
        tick();

        // Single-mode read of one byte
        pushTx(8'h5A);
        bus.EN = 1; bus.DIR = 0; bus.DEMAND = 0;
        tick();
        check("s_dreq_req", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1;
        tick();
        check("s_dreq_xfer", 32'(bus.DREQ), 32'd1);
        bus.IOR_N = 0;
        tick();
        check("s_oe",  32'(bus.DB_OE),  32'd1);
        check("s_db1", 32'(bus.DB_OUT), 32'h5A);
        tick();
        check("s_db2", 32'(bus.DB_OUT), 32'h5A);
        bus.IOR_N = 1;
        tick();
        check("s_gap_dreq", 32'(bus.DREQ),  32'd0);
        check("s_gap_oe",   32'(bus.DB_OE), 32'd0);
        tick();
        check("s_gap_hold", 32'(bus.DREQ), 32'd0);
        bus.DACK = 0;
        tick();
        tick();
        check("s_tx_empty", 32'(bus.DREQ),     32'd0);
        check("s_no_under", 32'(bus.UNDERRUN), 32'd0);
        bus.EN = 0;

        // Demand-mode writes into the rx FIFO
        bus.EN = 1; bus.DIR = 1; bus.DEMAND = 1;
        tick();
        check("d_dreq_req", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.DB_IN = wdata[i];
            bus.IOW_N = 0;
            tick();
            check("d_oe_off", 32'(bus.DB_OE), 32'd0);
            bus.IOW_N = 1;
            tick();
            check("d_dreq_held", 32'(bus.DREQ), 32'd1);
        end
        bus.DACK = 0; bus.EN = 0; bus.DEMAND = 0;
        tick();
        check("d_rxvalid", 32'(bus.RX_VALID), 32'd1);
        check("d_rx0", 32'(bus.RX_DATA), 32'h11);
        bus.RX_READY = 1;
        tick();
        check("d_rx1", 32'(bus.RX_DATA), 32'h22);
        tick();
        check("d_rx2", 32'(bus.RX_DATA), 32'h33);
        tick();
        bus.RX_READY = 0;
        check("d_rx_empty", 32'(bus.RX_VALID), 32'd0);

        // EOP during the second read of four queued bytes
        pushTx(8'hA1); pushTx(8'hA2); pushTx(8'hA3); pushTx(8'hA4);
        check("e_full", 32'(bus.TX_READY), 32'd0);
        pushTx(8'hEE);
        check("e_full_hold", 32'(bus.TX_READY), 32'd0);
        bus.EN = 1; bus.DIR = 0; bus.DEMAND = 1;
        tick();
        bus.DACK = 1;
        tick();
        iorCycle("e_r1", 8'hA1, 1'b0);
        check("e_dreq_cont", 32'(bus.DREQ),     32'd1);
        check("e_txready",   32'(bus.TX_READY), 32'd1);
        iorCycle("e_r2", 8'hA2, 1'b1);
        check("e_term_dreq", 32'(bus.DREQ),    32'd0);
        check("e_tcdone",    32'(bus.TC_DONE), 32'd1);
        tick();
        check("e_term_hold", 32'(bus.DREQ), 32'd0);
        bus.DACK = 0; bus.EN = 0;
        tick();
        bus.EN = 1;
        tick();
        bus.DACK = 1;
        tick();
        iorCycle("e_r3", 8'hA3, 1'b0);
        check("e_dreq_r3", 32'(bus.DREQ), 32'd1);
        iorCycle("e_r4", 8'hA4, 1'b0);
        check("e_drained", 32'(bus.DREQ), 32'd0);
        bus.DACK = 0; bus.EN = 0; bus.DEMAND = 0;
        tick();

        // Underrun: read strobe with the tx FIFO empty
        bus.EN = 1; bus.DIR = 1;
        tick();
        bus.DACK = 1;
        tick();
        bus.DIR = 0;
        bus.IOR_N = 0;
        tick();
        check("u_db", 32'(bus.DB_OUT),   32'hFF);
        check("u_oe", 32'(bus.DB_OE),    32'd1);
        check("u_flag", 32'(bus.UNDERRUN), 32'd1);
        bus.IOR_N = 1;
        tick();
        bus.DACK = 0; bus.EN = 0;
        tick();
        check("u_sticky",  32'(bus.UNDERRUN), 32'd1);
        check("t_sticky",  32'(bus.TC_DONE),  32'd1);
        bus.CLR = 1;
        tick();
        bus.CLR = 0;
        check("u_clr", 32'(bus.UNDERRUN), 32'd0);
        check("t_clr", 32'(bus.TC_DONE),  32'd0);

        // DACK abort while IOR is low
        pushTx(8'h77);
        bus.EN = 1; bus.DIR = 0;
        tick();
        bus.DACK = 1;
        tick();
        bus.IOR_N = 0;
        tick();
        check("a_db", 32'(bus.DB_OUT), 32'h77);
        bus.DACK = 0;
        tick();
        check("a_oe",   32'(bus.DB_OE), 32'd0);
        check("a_idle", 32'(bus.DREQ),  32'd0);
        bus.IOR_N = 1;
        tick();
        check("a_rereq", 32'(bus.DREQ), 32'd1);
        bus.DACK = 1;
        tick();
        bus.IOR_N = 0;
        tick();
        check("a_no_pop", 32'(bus.DB_OUT), 32'h77);
        bus.DACK = 0; bus.IOR_N = 1; bus.EN = 0;
        tick();
        check("a_abort2", 32'(bus.DREQ), 32'd0);

        // Reset with a full tx FIFO
        pushTx(8'h01); pushTx(8'h02); pushTx(8'h03);
        check("r_full", 32'(bus.TX_READY), 32'd0);
        rstN = 0;
        #1;
        check("r_dreq",     32'(bus.DREQ),     32'd0);
        check("r_oe",       32'(bus.DB_OE),    32'd0);
        check("r_db",       32'(bus.DB_OUT),   32'd0);
        check("r_txready",  32'(bus.TX_READY), 32'd1);
        check("r_rxvalid",  32'(bus.RX_VALID), 32'd0);
        check("r_tcdone",   32'(bus.TC_DONE),  32'd0);
        check("r_underrun", 32'(bus.UNDERRUN), 32'd0);
        bus.EN = 1; bus.DIR = 1;
        tick();
        tick();
        rstN = 1;
        check("r_no_dreq", 32'(bus.DREQ), 32'd1 - 32'd1);
        tick();
        check("r_dreq_after", 32'(bus.DREQ), 32'd1);
        bus.EN = 0;
        tick();
        bus.DIR = 0; bus.EN = 1;
        tick();
        tick();
        check("r_tx_empty", 32'(bus.DREQ), 32'd0);
        bus.EN = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
